// File: rtl/uart_arb_pkg.sv
// uart_arb_pkg: shared constants for the UART transmit arbiter.
//   NREQ_DEF      - number of requesters (fixed at 4)
//   SYNC_BYTE_DEF - frame start marker
//   TIMEOUT_DEF   - default payload stall limit in clk cycles
//   ID_W          - width of a requester index
//   state_t       - frame FSM state encoding, with its ST_* values
package uart_arb_pkg;

    localparam int unsigned NREQ_DEF      = 4;
    localparam logic [7:0]  SYNC_BYTE_DEF = 8'hA5;
    localparam int unsigned TIMEOUT_DEF   = 1000;
    localparam int unsigned ID_W          = 2;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE     = 3'd0;
    localparam state_t ST_HDR_SYNC = 3'd1;
    localparam state_t ST_HDR_ID   = 3'd2;
    localparam state_t ST_HDR_LEN  = 3'd3;
    localparam state_t ST_PAYLOAD  = 3'd4;
    localparam state_t ST_CSUM     = 3'd5;
    localparam state_t ST_DONE     = 3'd6;

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: 4-way round-robin pick with a rotating priority pointer.
//   clk, nrst - clock and synchronous active-low reset
//   req       - per-requester request vector
//   advance   - the current pick is being taken; move pointer past it
//   valid     - at least one request is present
//   id        - index of the picked requester
//   gnt       - one-hot form of id (all zero when !valid)
module rr_arbiter
    import uart_arb_pkg::*;
(
    input  logic                clk,
    input  logic                nrst,
    input  logic [NREQ_DEF-1:0] req,
    input  logic                advance,
    output logic                valid,
    output logic [ID_W-1:0]     id,
    output logic [NREQ_DEF-1:0] gnt
);

    logic [ID_W-1:0] ptr_q;
    logic [ID_W-1:0] idx;

    // Search upward from the pointer; the 2-bit add wraps 3 -> 0.
    always_comb begin
        valid = 1'b0;
        id    = '0;
        idx   = '0;
        for (int i = 0; i < NREQ_DEF; i++) begin
            idx = ptr_q + ID_W'(i);
            if (!valid && req[idx]) begin
                valid = 1'b1;
                id    = idx;
            end
        end
        gnt = '0;
        if (valid) begin
            gnt[id] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!nrst) begin
            ptr_q <= '0;
        end else if (advance && valid) begin
            ptr_q <= id + ID_W'(1);
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: grants one of four requesters a framed transmission into
// a UART transmit FIFO. Frame: SYNC_BYTE, id, len, len payload bytes, checksum
// (XOR of id, len and payload). Stalled payloads are padded with 8'h00.
//   clk, nrst    - clock and synchronous active-low reset
//   en           - allows new grants
//   req          - per-requester frame request, held until granted
//   req_len      - byte i = payload length of requester i
//   src_data     - byte i = current payload byte of requester i
//   src_valid    - per-requester payload byte valid
//   src_ready    - per-requester payload accept strobe (combinational)
//   gnt, busy    - one-hot frame owner, frame in progress
//   frame_done   - one-cycle pulse at the end of a frame
//   timeout_err  - pulses with frame_done when padding was inserted
//   uart_wdata, uart_wt_en - registered FIFO write port
//   uart_wt_full - FIFO almost-full; no byte is emitted while high
module uart_tx_arbiter
    import uart_arb_pkg::*;
#(
    parameter int unsigned NREQ      = NREQ_DEF,
    parameter logic [7:0]  SYNC_BYTE = SYNC_BYTE_DEF,
    parameter int unsigned TIMEOUT   = TIMEOUT_DEF
) (
    input  logic              clk,
    input  logic              nrst,
    input  logic              en,
    input  logic [NREQ-1:0]   req,
    input  logic [8*NREQ-1:0] req_len,
    input  logic [8*NREQ-1:0] src_data,
    input  logic [NREQ-1:0]   src_valid,
    output logic [NREQ-1:0]   src_ready,
    output logic [NREQ-1:0]   gnt,
    output logic              busy,
    output logic              frame_done,
    output logic              timeout_err,
    output logic [7:0]        uart_wdata,
    output logic              uart_wt_en,
    input  logic              uart_wt_full
);

    localparam int unsigned      STALL_W   = $clog2(TIMEOUT + 1);
    localparam logic [STALL_W-1:0] STALL_MAX = STALL_W'(TIMEOUT);

    state_t              state_q, state_d;
    logic [NREQ-1:0]     gnt_q, gnt_d;
    logic [ID_W-1:0]     id_q, id_d;
    logic [7:0]          len_q, len_d;
    logic [7:0]          cnt_q, cnt_d;
    logic [7:0]          csum_q, csum_d;
    logic [STALL_W-1:0]  stall_q, stall_d;
    logic [7:0]          wdata_q, wdata_d;
    logic                wt_en_q, wt_en_d;
    logic                done_q, done_d;
    logic                terr_q, terr_d;

    logic                arb_valid;
    logic [ID_W-1:0]     arb_id;
    logic [NREQ-1:0]     arb_gnt;
    logic                grant;
    logic                pad;
    logic                ready;
    logic                cur_valid;
    logic [7:0]          cur_data;
    logic                last;

    rr_arbiter u_rr_arbiter (
        .clk     (clk),
        .nrst    (nrst),
        .req     (req),
        .advance (grant),
        .valid   (arb_valid),
        .id      (arb_id),
        .gnt     (arb_gnt)
    );

    assign grant     = (state_q == ST_IDLE) && en && arb_valid;
    // Once the stall limit is hit it sticks for the rest of the frame and
    // doubles as the error flag.
    assign pad       = (stall_q == STALL_MAX);
    assign ready     = (state_q == ST_PAYLOAD) && !uart_wt_full && !pad;
    assign src_ready = ready ? gnt_q : '0;
    assign cur_valid = src_valid[id_q];
    assign cur_data  = src_data[8*id_q +: 8];
    assign last      = ((cnt_q + 8'd1) == len_q);

    assign gnt         = gnt_q;
    assign busy        = |gnt_q;
    assign frame_done  = done_q;
    assign timeout_err = terr_q;
    assign uart_wdata  = wdata_q;
    assign uart_wt_en  = wt_en_q;

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        id_d    = id_q;
        len_d   = len_q;
        cnt_d   = cnt_q;
        csum_d  = csum_q;
        stall_d = stall_q;
        wdata_d = wdata_q;
        wt_en_d = 1'b0;
        done_d  = 1'b0;
        terr_d  = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (grant) begin
                    gnt_d   = arb_gnt;
                    id_d    = arb_id;
                    len_d   = req_len[8*arb_id +: 8];
                    cnt_d   = '0;
                    csum_d  = '0;
                    stall_d = '0;
                    state_d = ST_HDR_SYNC;
                end
            end
            ST_HDR_SYNC: begin
                if (!uart_wt_full) begin
                    wdata_d = SYNC_BYTE;
                    wt_en_d = 1'b1;
                    state_d = ST_HDR_ID;
                end
            end
            ST_HDR_ID: begin
                if (!uart_wt_full) begin
                    wdata_d = 8'(id_q);
                    wt_en_d = 1'b1;
                    csum_d  = 8'(id_q);
                    state_d = ST_HDR_LEN;
                end
            end
            ST_HDR_LEN: begin
                if (!uart_wt_full) begin
                    wdata_d = len_q;
                    wt_en_d = 1'b1;
                    csum_d  = csum_q ^ len_q;
                    state_d = (len_q == 8'd0) ? ST_CSUM : ST_PAYLOAD;
                end
            end
            ST_PAYLOAD: begin
                if (!uart_wt_full) begin
                    if (pad) begin
                        // Zero filler leaves the checksum unchanged.
                        wdata_d = 8'h00;
                        wt_en_d = 1'b1;
                        cnt_d   = cnt_q + 8'd1;
                        if (last) state_d = ST_CSUM;
                    end else if (cur_valid) begin
                        wdata_d = cur_data;
                        wt_en_d = 1'b1;
                        csum_d  = csum_q ^ cur_data;
                        cnt_d   = cnt_q + 8'd1;
                        stall_d = '0;
                        if (last) state_d = ST_CSUM;
                    end else begin
                        stall_d = stall_q + STALL_W'(1);
                    end
                end
            end
            ST_CSUM: begin
                if (!uart_wt_full) begin
                    wdata_d = csum_q;
                    wt_en_d = 1'b1;
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                done_d  = 1'b1;
                terr_d  = pad;
                gnt_d   = '0;
                state_d = ST_IDLE;
            end
            default: begin
                gnt_d   = '0;
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!nrst) begin
            state_q <= ST_IDLE;
            gnt_q   <= '0;
            id_q    <= '0;
            len_q   <= '0;
            cnt_q   <= '0;
            csum_q  <= '0;
            stall_q <= '0;
            wdata_q <= '0;
            wt_en_q <= 1'b0;
            done_q  <= 1'b0;
            terr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            id_q    <= id_d;
            len_q   <= len_d;
            cnt_q   <= cnt_d;
            csum_q  <= csum_d;
            stall_q <= stall_d;
            wdata_q <= wdata_d;
            wt_en_q <= wt_en_d;
            done_q  <= done_d;
            terr_q  <= terr_d;
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: directed, table-driven bench for uart_tx_arbiter.
// Inputs change 1 ns after the rising edge; outputs and FIFO writes are
// sampled on the falling edge.
module tb_uart_tx_arbiter;

    localparam int TO = 1000;

    logic        clk = 1'b0;
    logic        nrst;
    logic        en;
    logic [3:0]  req;
    logic [31:0] req_len;
    logic [31:0] src_data;
    logic [3:0]  src_valid;
    logic [3:0]  src_ready;
    logic [3:0]  gnt;
    logic        busy;
    logic        frame_done;
    logic        timeout_err;
    logic [7:0]  uart_wdata;
    logic        uart_wt_en;
    logic        uart_wt_full;

    uart_tx_arbiter #(
        .NREQ      (4),
        .SYNC_BYTE (8'hA5),
        .TIMEOUT   (TO)
    ) dut (
        .clk          (clk),
        .nrst         (nrst),
        .en           (en),
        .req          (req),
        .req_len      (req_len),
        .src_data     (src_data),
        .src_valid    (src_valid),
        .src_ready    (src_ready),
        .gnt          (gnt),
        .busy         (busy),
        .frame_done   (frame_done),
        .timeout_err  (timeout_err),
        .uart_wdata   (uart_wdata),
        .uart_wt_en   (uart_wt_en),
        .uart_wt_full (uart_wt_full)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0] req;
        logic [7:0] len;
        logic [7:0] p0;
        logic [7:0] p1;
        logic [7:0] p2;
        logic [3:0] exp_gnt;
        logic [7:0] exp_id;
        logic [7:0] exp_csum;
    } vec_t;

    int         checks = 0;
    int         errors = 0;
    int         cyc = 0;
    int         done_cnt = 0;
    int         terr_cnt = 0;
    int         terr_alone = 0;
    logic [7:0] wq[$];
    int         wcyc[$];
    logic [7:0] eq[$];
    logic [3:0] glog[$];
    logic [7:0] sq[4][$];
    logic [3:0] take = 4'b0;
    logic [3:0] gprev = 4'b0;
    vec_t       vt[5];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic drive_src();
        for (int i = 0; i < 4; i++) begin
            if (sq[i].size() > 0) begin
                src_valid[i]       = 1'b1;
                src_data[8*i +: 8] = sq[i][0];
            end else begin
                src_valid[i]       = 1'b0;
                src_data[8*i +: 8] = 8'h00;
            end
        end
    endtask

    // One clock: sample on the falling edge, then advance sources after the
    // rising edge. Returns 1 ns after the rising edge.
    task automatic step();
        @(negedge clk);
        cyc++;
        if (uart_wt_en === 1'b1) begin
            wq.push_back(uart_wdata);
            wcyc.push_back(cyc);
        end
        if (frame_done === 1'b1) done_cnt++;
        if (timeout_err === 1'b1) begin
            terr_cnt++;
            if (frame_done !== 1'b1) terr_alone++;
        end
        if (gnt !== 4'b0 && gprev === 4'b0) glog.push_back(gnt);
        gprev = gnt;
        take  = src_ready & src_valid;
        @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) begin
            if (take[i] === 1'b1 && sq[i].size() > 0) void'(sq[i].pop_front());
        end
        drive_src();
    endtask

    task automatic wait_done(input string name, input int bound);
        int start = done_cnt;
        int n = 0;
        while (done_cnt == start && n < bound) begin
            step();
            n++;
        end
        chk({name, "_done"}, done_cnt - start, 1);
    endtask

    task automatic check_frame(input string name);
        chk({name, "_nbytes"}, wq.size(), eq.size());
        for (int k = 0; k < eq.size(); k++) begin
            chk($sformatf("%s_byte%0d", name, k),
                (k < wq.size()) ? {24'h0, wq[k]} : 32'hDEAD, {24'h0, eq[k]});
        end
        wq.delete();
        wcyc.delete();
    endtask

    task automatic clear_src();
        for (int i = 0; i < 4; i++) sq[i].delete();
        drive_src();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int snap;
        int bad;
        int t0;
        int n;

        nrst = 1'b0; en = 1'b0; req = 4'b0; req_len = 32'h0;
        uart_wt_full = 1'b0; src_valid = 4'b0; src_data = 32'h0;

        vt[0] = '{4'b0001, 8'd2, 8'h11, 8'h22, 8'h00, 4'b0001, 8'd0, 8'h31};
        vt[1] = '{4'b0010, 8'd1, 8'h7F, 8'h00, 8'h00, 4'b0010, 8'd1, 8'h7F};
        vt[2] = '{4'b1001, 8'd3, 8'h01, 8'h02, 8'h03, 4'b1000, 8'd3, 8'h00};
        vt[3] = '{4'b0110, 8'd0, 8'h00, 8'h00, 8'h00, 4'b0010, 8'd1, 8'h01};
        vt[4] = '{4'b0100, 8'd3, 8'h80, 8'h40, 8'h01, 4'b0100, 8'd2, 8'hC0};

        // Reset state
        repeat (3) step();
        chk("rst_gnt", gnt, 0);
        chk("rst_busy", busy, 0);
        chk("rst_frame_done", frame_done, 0);
        chk("rst_timeout_err", timeout_err, 0);
        chk("rst_wt_en", uart_wt_en, 0);
        chk("rst_wdata", uart_wdata, 0);
        chk("rst_src_ready", src_ready, 0);
        nrst = 1'b1;
        en   = 1'b1;
        step();
        wq.delete();
        wcyc.delete();

        // Table-driven single frames; pointer walks 0 -> 1 -> 2 -> 0 -> 2 -> 3
        for (int v = 0; v < 5; v++) begin
            for (int i = 0; i < 4; i++) begin
                sq[i].delete();
                if (vt[v].req[i]) begin
                    if (vt[v].len > 0) sq[i].push_back(vt[v].p0);
                    if (vt[v].len > 1) sq[i].push_back(vt[v].p1);
                    if (vt[v].len > 2) sq[i].push_back(vt[v].p2);
                end
            end
            drive_src();
            req_len = {4{vt[v].len}};
            t0  = terr_cnt;
            req = vt[v].req;
            step();
            chk($sformatf("vec%0d_gnt", v), gnt, vt[v].exp_gnt);
            chk($sformatf("vec%0d_busy", v), busy, 1);
            req = 4'b0;
            wait_done($sformatf("vec%0d", v), 200);
            eq.delete();
            eq.push_back(8'hA5);
            eq.push_back(vt[v].exp_id);
            eq.push_back(vt[v].len);
            if (vt[v].len > 0) eq.push_back(vt[v].p0);
            if (vt[v].len > 1) eq.push_back(vt[v].p1);
            if (vt[v].len > 2) eq.push_back(vt[v].p2);
            eq.push_back(vt[v].exp_csum);
            check_frame($sformatf("vec%0d", v));
            chk($sformatf("vec%0d_terr", v), terr_cnt - t0, 0);
            chk($sformatf("vec%0d_busy_end", v), busy, 0);
            clear_src();
            step();
        end

        // FIFO full for 20 cycles in the middle of a payload
        sq[2] = '{8'h10, 8'h20, 8'h30, 8'h40};
        drive_src();
        req_len = {4{8'd4}};
        req = 4'b0100;
        step();
        chk("full_gnt", gnt, 4'b0100);
        req = 4'b0;
        n = 0;
        while (wq.size() < 5 && n < 50) begin
            step();
            n++;
        end
        chk("full_reach_payload", (wq.size() >= 5), 1);
        uart_wt_full = 1'b1;
        step();
        snap = wq.size();
        bad = 0;
        repeat (19) begin
            step();
            if (src_ready !== 4'b0) bad++;
        end
        chk("full_no_write", wq.size(), snap);
        chk("full_src_ready_low", bad, 0);
        chk("full_busy_held", busy, 1);
        uart_wt_full = 1'b0;
        wait_done("full", 100);
        eq = '{8'hA5, 8'h02, 8'h04, 8'h10, 8'h20, 8'h30, 8'h40, 8'h46};
        check_frame("full");
        clear_src();
        step();

        // Payload stall past the timeout: one real byte, two zero fillers
        sq[1] = '{8'h5A};
        drive_src();
        req_len = {4{8'd3}};
        t0  = terr_cnt;
        req = 4'b0010;
        step();
        chk("to_gnt", gnt, 4'b0010);
        req = 4'b0;
        wait_done("to", TO + 100);
        chk("to_terr_pulse", terr_cnt - t0, 1);
        chk("to_terr_with_done", terr_alone, 0);
        if (wcyc.size() >= 6) begin
            chk("to_stall_gap", wcyc[4] - wcyc[3], TO + 1);
            chk("to_pad_gap", wcyc[5] - wcyc[4], 1);
        end else begin
            chk("to_write_count", wcyc.size(), 7);
        end
        eq = '{8'hA5, 8'h01, 8'h03, 8'h5A, 8'h00, 8'h00, 8'h58};
        check_frame("to");
        clear_src();
        step();

        // en low blocks grants; raising it grants one cycle later
        req_len = 32'h0;
        en  = 1'b0;
        req = 4'b0100;
        bad = 0;
        repeat (5) begin
            step();
            if (gnt !== 4'b0 || busy !== 1'b0) bad++;
        end
        chk("en0_no_grant", bad, 0);
        en = 1'b1;
        step();
        chk("en1_gnt", gnt, 4'b0100);
        req = 4'b0;
        wait_done("en1", 50);
        eq = '{8'hA5, 8'h02, 8'h00, 8'h02};
        check_frame("en1");
        step();

        // Reset in the middle of a payload (pointer is 2 afterwards if not reset)
        sq[1] = '{8'h01, 8'h02, 8'h03, 8'h04};
        drive_src();
        req_len = {4{8'd4}};
        req = 4'b0010;
        step();
        chk("mrst_gnt", gnt, 4'b0010);
        req = 4'b0;
        n = 0;
        while (wq.size() < 4 && n < 50) begin
            step();
            n++;
        end
        chk("mrst_reach_payload", (wq.size() >= 4), 1);
        t0 = done_cnt;
        nrst = 1'b0;
        step();
        chk("mrst_busy", busy, 0);
        chk("mrst_gnt0", gnt, 0);
        chk("mrst_wt_en", uart_wt_en, 0);
        snap = wq.size();
        nrst = 1'b1;
        clear_src();
        repeat (3) step();
        chk("mrst_no_write", wq.size(), snap);
        chk("mrst_no_done", done_cnt - t0, 0);
        wq.delete();
        wcyc.delete();
        req_len = 32'h0;
        req = 4'b0101;
        step();
        chk("mrst_next_gnt", gnt, 4'b0001);
        req = 4'b0;
        wait_done("mrst_next", 50);
        eq = '{8'hA5, 8'h00, 8'h00, 8'h00};
        check_frame("mrst_next");

        // All four held with len 0: grants rotate 0,1,2,3 then wrap to 0
        nrst = 1'b0;
        repeat (2) step();
        nrst = 1'b1;
        wq.delete();
        wcyc.delete();
        glog.delete();
        req_len = 32'h0;
        req = 4'b1111;
        for (int f = 0; f < 4; f++) wait_done($sformatf("rr%0d", f), 50);
        req = 4'b0;
        wait_done("rr_tail", 50);
        chk("rr_ngrants", glog.size(), 5);
        for (int f = 0; f < 5; f++) begin
            chk($sformatf("rr_gnt%0d", f), (f < glog.size()) ? {28'h0, glog[f]} : 32'hDEAD,
                32'h1 << (f % 4));
        end
        eq.delete();
        for (int f = 0; f < 5; f++) begin
            eq.push_back(8'hA5);
            eq.push_back(8'(f % 4));
            eq.push_back(8'h00);
            eq.push_back(8'(f % 4));
        end
        check_frame("rr");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 The block SHALL have parameter NREQ, default 4, meaning the number of requesters (fixed at 4 for this release).
REQ-002 The block SHALL have parameter SYNC_BYTE, default 8'hA5, meaning the frame start marker.
REQ-003 The block SHALL have parameter TIMEOUT, default 1000, meaning the payload stall limit in clk cycles.
REQ-004 The block SHALL have port clk, input, 1 bit, the 50 MHz system clock; all logic is on its rising edge.
REQ-005 The block SHALL have port nrst, input, 1 bit, reset: synchronous, active-low.
REQ-006 The block SHALL have port en, input, 1 bit; when low, no new grant is issued.
REQ-007 The block SHALL have port req, input, 4 bits, a per-requester frame request, held until granted.
REQ-008 The block SHALL have port req_len, input, 32 bits; byte i is the payload length (0..255) of requester i.
REQ-009 The block SHALL have port src_data, input, 32 bits; byte i is the payload byte of requester i.
REQ-010 The block SHALL have port src_valid, input, 4 bits, marking the payload byte valid per requester.
REQ-011 The block SHALL have port src_ready, output, 4 bits, the payload accept strobe per requester.
REQ-012 The block SHALL have port gnt, output, 4 bits, the one-hot owner of the current frame.
REQ-013 The block SHALL have port busy, output, 1 bit, high while a frame is in progress.
REQ-014 The block SHALL have port frame_done, output, 1 bit, a one-cycle pulse after the checksum byte is written.
REQ-015 The block SHALL have port timeout_err, output, 1 bit, a one-cycle pulse coincident with frame_done when padding occurred.
REQ-016 The block SHALL have port uart_wdata, output, 8 bits, the byte driven to the UART transmit-FIFO write port.
REQ-017 The block SHALL have port uart_wt_en, output, 1 bit, the transmit-FIFO write strobe.
REQ-018 The block SHALL have port uart_wt_full, input, 1 bit, the transmit-FIFO almost-full flag.

Function
REQ-019 Frame format SHALL be: SYNC_BYTE, source id (0..3), len, then len payload bytes, then checksum = XOR of id, len and all payload bytes.
REQ-020 States SHALL be IDLE, HDR_SYNC, HDR_ID, HDR_LEN, PAYLOAD, CSUM, DONE.
REQ-021 IDLE: when en=1 and req!=0 in cycle N, the round-robin winner SHALL be latched with its req_len, gnt and busy SHALL be asserted in cycle N+1, and the state SHALL go to HDR_SYNC.
REQ-022 Round-robin SHALL search upward from the pointer, wrapping 3->0; the pointer is 0 after reset and becomes winner+1 mod 4 on each grant.
REQ-023 A header, payload or checksum state SHALL emit its byte only in a cycle with uart_wt_full=0; uart_wdata and uart_wt_en are registered and appear the following cycle, and uart_wt_en is a single-cycle pulse per byte.
REQ-024 While uart_wt_full=1, the block SHALL hold its state and emit nothing.
REQ-025 HDR_LEN SHALL go to CSUM when len=0, otherwise to PAYLOAD.
REQ-026 PAYLOAD: src_ready[g] SHALL equal (state==PAYLOAD && !uart_wt_full), combinationally, for the granted g only; a byte is transferred when src_valid[g] && src_ready[g].
REQ-027 PAYLOAD SHALL go to CSUM after len transfers.
REQ-028 The stall counter SHALL count consecutive PAYLOAD cycles with src_ready=1 and src_valid=0, and reset on each transfer.
REQ-029 When the stall counter reaches TIMEOUT, each remaining payload byte SHALL be written as 8'h00 (included in the checksum), src_ready SHALL be deasserted, and the error SHALL be flagged.
REQ-030 CSUM SHALL write the checksum, then DONE SHALL pulse frame_done (and timeout_err if flagged), clear gnt/busy and return to IDLE; a new grant is possible in the cycle after DONE.
REQ-031 Deassertion of req or en mid-frame SHALL NOT abort the frame.
REQ-032 Checksum and byte count SHALL be 8-bit; the checksum wraps naturally.

Reset
REQ-033 With nrst=0 at a rising clk edge, the block SHALL go to IDLE and clear all outputs (gnt, busy, frame_done, timeout_err, uart_wt_en, uart_wdata, src_ready) and the pointer, stall counter and checksum to 0.
REQ-034 A mid-frame reset SHALL abort the frame, with no further writes.

Structure
REQ-035 Package uart_arb_pkg SHALL hold the state enum, SYNC_BYTE, NREQ and the TIMEOUT default.
REQ-036 Sub-module rr_arbiter SHALL implement the 4-way round-robin pick and pointer.

Verification
REQ-037 Bench SHALL cover: req=0001, len=2, bytes 11,22, full=0 -> writes A5,00,02,11,22,31; one frame_done.
REQ-038 Bench SHALL cover: req=1111 held, len=0 for all -> grants in order 0,1,2,3; frames A5,i,00,i.
REQ-039 Bench SHALL cover: wt_full=1 for 20 cycles mid-payload -> no uart_wt_en; resumes with no byte lost or duplicated.
REQ-040 Bench SHALL cover: len=3, source supplies 1 byte (5A) then stalls for TIMEOUT cycles -> writes 5A,00,00; checksum matches; timeout_err=1.
REQ-041 Bench SHALL cover: nrst=0 during PAYLOAD -> next cycle busy=0, gnt=0, no uart_wt_en; the next grant goes to requester 0.
REQ-042 Bench SHALL cover: en=0 with req=0100 -> no grant; en=1 -> gnt=0100 one cycle later.
